ping_pong_fill_scheduler: RTL

- Sequences a two-bank ping-pong buffer pair between one streaming producer (valid/ready) and one consumer, such as a matmul/systolic wrapper.
- Generates bank write enables and write addresses, tracks per-bank occupancy, issues consumer start pulses, and retires banks on consumer done.
- Sits between the input DMA/stream and the ping-pong buffer banks; its `rd_bank` output drives the bank output mux select.

---
 rtl/ping_pong_fill_scheduler.sv | 118 +++++++++++
 1 files changed

// File: rtl/ping_pong_fill_scheduler.sv
// Ping-pong buffer scheduler: fills two banks alternately from a valid/ready stream
// and hands each full bank to a single consumer with start/done handshaking.
//
// state   | meaning
// EMPTY   | bank free, may be written when wr_sel points to it
// FILLING | bank partially written
// FULL    | bank complete, waiting for the consumer
// BUSY    | consumer owns the bank (rd_bank)
module ping_pong_fill_scheduler #(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  wr_bank0_en,
    output logic                  wr_bank1_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  consume_start,
    output logic                  rd_bank,
    input  logic                  consume_done,
    output logic [1:0]            bank0_state,
    output logic [1:0]            bank1_state,
    output logic [CNT_WIDTH-1:0]  fills_done,
    output logic                  err
);

    typedef enum logic [1:0] {EMPTY = 2'd0, FILLING = 2'd1, FULL = 2'd2, BUSY = 2'd3} bank_st_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    bank_st_t               st     [2];
    bank_st_t               st_n   [2];
    logic                   wr_sel, wr_sel_n;
    logic                   rd_sel, rd_sel_n;
    logic [ADDR_WIDTH-1:0]  wr_cnt, wr_cnt_n;
    logic [CNT_WIDTH-1:0]   fills_n;
    logic                   err_n;
    logic                   start_n;
    logic                   rd_bank_n;
    logic                   accept;
    logic                   any_busy;
    logic                   start_c;
    logic                   done_ok;

    assign any_busy    = (st[0] == BUSY) || (st[1] == BUSY);
    assign start_c     = (st[rd_sel] == FULL) && !any_busy;
    assign done_ok     = consume_done && (st[rd_bank] == BUSY);
    assign in_ready    = !rst && ((st[wr_sel] == EMPTY) || (st[wr_sel] == FILLING));
    assign accept      = in_valid && in_ready;
    assign wr_bank0_en = accept && !wr_sel;
    assign wr_bank1_en = accept && wr_sel;
    assign wr_addr     = wr_cnt;
    assign bank0_state = st[0];
    assign bank1_state = st[1];

    always_comb begin
        st_n      = st;
        wr_sel_n  = wr_sel;
        rd_sel_n  = rd_sel;
        wr_cnt_n  = wr_cnt;
        fills_n   = fills_done;
        err_n     = err;
        start_n   = start_c;
        rd_bank_n = rd_bank;

        if (accept) begin
            if (wr_cnt == LAST_ADDR) begin
                st_n[wr_sel] = FULL;
                wr_cnt_n     = '0;
                wr_sel_n     = ~wr_sel;
                fills_n      = fills_done + CNT_WIDTH'(1);
            end else begin
                st_n[wr_sel] = FILLING;
                wr_cnt_n     = wr_cnt + ADDR_WIDTH'(1);
            end
        end

        // start needs no BUSY bank and done needs one, so these never collide
        if (start_c) begin
            st_n[rd_sel] = BUSY;
            rd_bank_n    = rd_sel;
        end

        if (done_ok) begin
            st_n[rd_bank] = EMPTY;
            rd_sel_n      = ~rd_sel;
        end else if (consume_done) begin
            err_n = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st[0]         <= EMPTY;
            st[1]         <= EMPTY;
            wr_sel        <= 1'b0;
            rd_sel        <= 1'b0;
            wr_cnt        <= '0;
            fills_done    <= '0;
            err           <= 1'b0;
            consume_start <= 1'b0;
            rd_bank       <= 1'b0;
        end else begin
            st            <= st_n;
            wr_sel        <= wr_sel_n;
            rd_sel        <= rd_sel_n;
            wr_cnt        <= wr_cnt_n;
            fills_done    <= fills_n;
            err           <= err_n;
            consume_start <= start_n;
            rd_bank       <= rd_bank_n;
        end
    end

endmodule
